mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16x16 signed parity-checked multiplier among N_REQ requesters. It accepts one operand pair at a time from the winning requester and drives the multiplier request/acknowledge handshake. It then waits for the result and returns result, result parity and argument-parity error to the originating requester only. A watchdog aborts stalled transactions so a hung multiplier cannot lock out requesters.

---
 rtl/mult_arbiter_if.sv | 45 ++++
 rtl/mult_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mult_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// Requester-side and multiplier-side handshake bundle for mult_arbiter.
// The arbiter connects through the slave modport; requesters and the multiplier use master.
interface mult_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [16*N_REQ-1:0] req_arg_a;
    logic [16*N_REQ-1:0] req_arg_b;
    logic [N_REQ-1:0]    req_a_parity;
    logic [N_REQ-1:0]    req_b_parity;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_result;
    logic                rsp_result_parity;
    logic                rsp_parity_error;
    logic                rsp_timeout;
    logic                mult_req;
    logic [15:0]         mult_arg_a;
    logic [15:0]         mult_arg_b;
    logic                mult_a_parity;
    logic                mult_b_parity;
    logic                mult_ack;
    logic                mult_result_rdy;
    logic [31:0]         mult_result;
    logic                mult_result_parity;
    logic                mult_arg_parity_error;

    modport slave (
        input  req_valid, req_arg_a, req_arg_b, req_a_parity, req_b_parity,
        output req_ready, rsp_valid, rsp_result, rsp_result_parity,
        output rsp_parity_error, rsp_timeout,
        output mult_req, mult_arg_a, mult_arg_b, mult_a_parity, mult_b_parity,
        input  mult_ack, mult_result_rdy, mult_result, mult_result_parity,
        input  mult_arg_parity_error
    );

    modport master (
        output req_valid, req_arg_a, req_arg_b, req_a_parity, req_b_parity,
        input  req_ready, rsp_valid, rsp_result, rsp_result_parity,
        input  rsp_parity_error, rsp_timeout,
        input  mult_req, mult_arg_a, mult_arg_b, mult_a_parity, mult_b_parity,
        output mult_ack, mult_result_rdy, mult_result, mult_result_parity,
        output mult_arg_parity_error
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one parity-checked 16x16 multiplier
// among N_REQ requesters, with a watchdog that aborts stalled transactions.
module mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    mult_arbiter_if.slave            bus,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_RESPOND  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] ptr_next_s;
    logic [IDW-1:0] winner_s;
    logic [CW-1:0]  wd_cnt_r;
    logic           wd_expired_s;
    logic           grant_s;
    logic           capture_s;
    logic           timeout_s;

    function automatic logic [N_REQ-1:0] one_hot(input logic [IDW-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin pick: first pending requester at or after ptr, wrapping
    always_comb begin
        int             pos_v;
        logic [IDW-1:0] idx_v;
        logic           found_v;
        winner_s = '0;
        found_v  = 1'b0;
        pos_v    = 0;
        idx_v    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos_v = int'(ptr_r) + k;
            if (pos_v >= N_REQ) begin
                pos_v = pos_v - N_REQ;
            end else begin
                pos_v = pos_v;
            end
            idx_v = IDW'(pos_v);
            if (!found_v && bus.req_valid[idx_v]) begin
                found_v  = 1'b1;
                winner_s = idx_v;
            end else begin
                found_v  = found_v;
            end
        end
    end

    assign wd_expired_s = (wd_cnt_r == CW'(TIMEOUT - 1));
    assign ptr_next_s   = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Next-state logic; a real result on the expiry edge wins over the abort
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    grant_s      = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.mult_ack && bus.mult_result_rdy) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RESPOND;
                end else if (wd_expired_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_RESPOND;
                end else if (bus.mult_ack) begin
                    state_next_s = ST_WAIT_RES;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT_RES: begin
                if (bus.mult_result_rdy) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RESPOND;
                end else if (wd_expired_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_RESPOND;
                end else begin
                    state_next_s = ST_WAIT_RES;
                end
            end
            ST_RESPOND: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Round-robin pointer advances past the winner as the response leaves
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (state_r == ST_RESPOND) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Watchdog counts every ISSUE/WAIT_RES cycle of the current transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= '0;
        end else if (grant_s) begin
            wd_cnt_r <= '0;
        end else if (state_r == ST_ISSUE || state_r == ST_WAIT_RES) begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            busy                  <= 1'b0;
            grant_id              <= '0;
            bus.req_ready         <= '0;
            bus.rsp_valid         <= '0;
            bus.rsp_result        <= 32'd0;
            bus.rsp_result_parity <= 1'b0;
            bus.rsp_parity_error  <= 1'b0;
            bus.rsp_timeout       <= 1'b0;
            bus.mult_req          <= 1'b0;
            bus.mult_arg_a        <= 16'd0;
            bus.mult_arg_b        <= 16'd0;
            bus.mult_a_parity     <= 1'b0;
            bus.mult_b_parity     <= 1'b0;
        end else begin
            busy         <= (state_next_s != ST_IDLE);
            bus.mult_req <= (state_next_s == ST_ISSUE);
            bus.rsp_valid <= (state_next_s == ST_RESPOND) ? one_hot(grant_id) : '0;
            if (grant_s) begin
                grant_id          <= winner_s;
                bus.req_ready     <= one_hot(winner_s);
                bus.mult_arg_a    <= bus.req_arg_a[{winner_s, 4'b0000} +: 16];
                bus.mult_arg_b    <= bus.req_arg_b[{winner_s, 4'b0000} +: 16];
                bus.mult_a_parity <= bus.req_a_parity[winner_s];
                bus.mult_b_parity <= bus.req_b_parity[winner_s];
            end else begin
                bus.req_ready     <= '0;
            end
            if (capture_s) begin
                bus.rsp_result        <= bus.mult_result;
                bus.rsp_result_parity <= bus.mult_result_parity;
                bus.rsp_parity_error  <= bus.mult_arg_parity_error;
                bus.rsp_timeout       <= 1'b0;
            end else if (timeout_s) begin
                bus.rsp_result        <= 32'd0;
                bus.rsp_result_parity <= 1'b0;
                bus.rsp_parity_error  <= 1'b0;
                bus.rsp_timeout       <= 1'b1;
            end else begin
                bus.rsp_timeout       <= bus.rsp_timeout;
            end
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed plus randomized bench for mult_arbiter; the bench plays both the
// requesters and the multiplier and predicts grants and responses itself.
module tb_mult_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [1:0] grant_id;

    always #5 clk = ~clk;

    mult_arbiter_if #(.N_REQ(N)) bus ();

    mult_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ptr_m = 0;
    logic [N-1:0] pend = '0;
    logic [15:0] a_m [N];
    logic [15:0] b_m [N];
    logic        pa_m [N];
    logic        pb_m [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int w);
        logic [N-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Spec rule: first pending requester searching upward from ptr, modulo N
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        bus.req_valid = pend;
        for (int i = 0; i < N; i++) begin
            bus.req_arg_a[16*i +: 16] = a_m[i];
            bus.req_arg_b[16*i +: 16] = b_m[i];
            bus.req_a_parity[i]       = pa_m[i];
            bus.req_b_parity[i]       = pb_m[i];
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        pend[i] = 1'b1;
        a_m[i]  = a;
        b_m[i]  = b;
        pa_m[i] = ^a;
        pb_m[i] = ^b;
    endtask

    // One transaction, entered in an IDLE cycle. ack_dly < 0 means the multiplier never acks.
    task automatic do_txn(input int ack_dly, input int res_dly, input logic perr,
                          input logic keep, input string tag);
        int          w;
        logic [31:0] prod;
        drive_reqs();
        w = pick(pend, ptr_m);
        tick();
        chk({tag, "/ready"},   bus.req_ready, oh(w));
        chk({tag, "/grant"},   grant_id, w);
        chk({tag, "/mreq"},    bus.mult_req, 1);
        chk({tag, "/busy"},    busy, 1);
        chk({tag, "/arg_a"},   bus.mult_arg_a, a_m[w]);
        chk({tag, "/arg_b"},   bus.mult_arg_b, b_m[w]);
        chk({tag, "/arg_par"}, {bus.mult_a_parity, bus.mult_b_parity}, {pa_m[w], pb_m[w]});
        chk({tag, "/rsp_early"}, bus.rsp_valid, 0);
        if (!keep) pend[w] = 1'b0;
        drive_reqs();
        prod = $signed(a_m[w]) * $signed(b_m[w]);
        if (ack_dly < 0) begin
            for (int c = 1; c < TO; c++) tick();
            chk({tag, "/to_early"}, bus.rsp_valid, 0);
            chk({tag, "/to_mreq"},  bus.mult_req, 1);
            tick();
            chk({tag, "/to_rsp"},   bus.rsp_valid, oh(w));
            chk({tag, "/to_flag"},  bus.rsp_timeout, 1);
            chk({tag, "/to_data"},  {bus.rsp_result, bus.rsp_result_parity, bus.rsp_parity_error}, 0);
            chk({tag, "/to_mreq_lo"}, bus.mult_req, 0);
        end else begin
            for (int c = 0; c < ack_dly; c++) begin
                bus.mult_result_rdy = 1'($urandom_range(0, 1));
                bus.mult_result     = $urandom;
                tick();
            end
            bus.mult_ack        = 1'b1;
            bus.mult_result_rdy = (res_dly == 0);
            bus.mult_result     = (res_dly == 0) ? prod : 32'hDEAD_BEEF;
            bus.mult_result_parity    = ^prod;
            bus.mult_arg_parity_error = perr;
            tick();
            bus.mult_ack        = 1'b0;
            bus.mult_result_rdy = 1'b0;
            if (res_dly > 0) begin
                for (int c = 1; c < res_dly; c++) begin
                    chk({tag, "/wait_mreq"}, bus.mult_req, 0);
                    bus.mult_ack = 1'($urandom_range(0, 1));
                    tick();
                end
                bus.mult_ack        = 1'b0;
                bus.mult_result_rdy = 1'b1;
                bus.mult_result     = prod;
                tick();
                bus.mult_result_rdy = 1'b0;
            end
            bus.mult_result = 32'hDEAD_BEEF;
            chk({tag, "/rsp"},     bus.rsp_valid, oh(w));
            chk({tag, "/result"},  bus.rsp_result, prod);
            chk({tag, "/rpar"},    bus.rsp_result_parity, ^prod);
            chk({tag, "/perr"},    bus.rsp_parity_error, perr);
            chk({tag, "/timeout"}, bus.rsp_timeout, 0);
            chk({tag, "/mreq_lo"}, bus.mult_req, 0);
        end
        ptr_m = (w + 1) % N;
        tick();
        chk({tag, "/rsp_pulse"}, bus.rsp_valid, 0);
        chk({tag, "/idle_gap"},  busy, 0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_arg_a = '0;
        bus.req_arg_b = '0;
        bus.req_a_parity = '0;
        bus.req_b_parity = '0;
        bus.mult_ack = 1'b0;
        bus.mult_result_rdy = 1'b0;
        bus.mult_result = 32'd0;
        bus.mult_result_parity = 1'b0;
        bus.mult_arg_parity_error = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_m[i] = 16'd0; b_m[i] = 16'd0; pa_m[i] = 1'b0; pb_m[i] = 1'b0;
        end

        rst = 1'b1;
        repeat (3) tick();
        chk("reset/busy",  busy, 0);
        chk("reset/grant", grant_id, 0);
        chk("reset/ready", bus.req_ready, 0);
        chk("reset/rsp",   bus.rsp_valid, 0);
        chk("reset/mreq",  bus.mult_req, 0);
        chk("reset/data",  {bus.rsp_result, bus.rsp_timeout, bus.mult_arg_a, bus.mult_arg_b}, 0);
        rst = 1'b0;

        // All four pending from reset, each held until its own ready
        for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom));
        for (int i = 0; i < N; i++) do_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, 1'b0, "all4");

        set_req(1, 16'h7FFF, 16'h7FFF);
        do_txn(0, 3, 1'b0, 1'b0, "max_pos");

        // Grant 2 leaves ptr at 3, so 3 beats 0
        set_req(2, 16'($urandom), 16'($urandom));
        do_txn(1, 1, 1'b0, 1'b0, "fair_pre");
        set_req(0, 16'($urandom), 16'($urandom));
        set_req(3, 16'($urandom), 16'($urandom));
        do_txn(0, 2, 1'b0, 1'b0, "fair_3");
        do_txn(0, 1, 1'b0, 1'b0, "fair_0");

        set_req(1, 16'h1234, 16'h0042);
        do_txn(-1, 0, 1'b0, 1'b0, "timeout");
        set_req(2, 16'hFFF0, 16'h0100);
        do_txn(1, 2, 1'b0, 1'b0, "post_to");

        set_req(3, 16'h8000, 16'h8000);
        do_txn(0, 0, 1'b1, 1'b0, "min_lat");

        set_req(2, 16'h0003, 16'hFFFD);
        do_txn(0, 1, 1'b0, 1'b1, "held_a");
        do_txn(2, 0, 1'b0, 1'b0, "held_b");

        // Reset while waiting for the result abandons the transaction
        set_req(2, 16'h00FF, 16'h0101);
        drive_reqs();
        tick();
        chk("rst_mid/mreq", bus.mult_req, 1);
        pend[2] = 1'b0;
        drive_reqs();
        bus.mult_ack = 1'b1;
        tick();
        bus.mult_ack = 1'b0;
        tick();
        chk("rst_mid/waiting", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ptr_m = 0;
        chk("rst_mid/rsp",   bus.rsp_valid, 0);
        chk("rst_mid/out",   {busy, grant_id, bus.mult_req, bus.req_ready}, 0);
        chk("rst_mid/data",  {bus.rsp_result, bus.mult_arg_a, bus.mult_arg_b}, 0);
        bus.mult_result_rdy = 1'b1;
        bus.mult_result     = 32'h1234_5678;
        tick();
        bus.mult_result_rdy = 1'b0;
        chk("stray_rdy/rsp",  bus.rsp_valid, 0);
        chk("stray_rdy/busy", busy, 0);
        set_req(0, 16'($urandom), 16'($urandom));
        set_req(3, 16'hFFFF, 16'h0005);
        do_txn(0, 1, 1'b0, 1'b0, "post_rst0");
        do_txn(1, 0, 1'b0, 1'b0, "neg_x5");

        // Random arrivals against the round-robin model
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    a_m[i]  = 16'($urandom);
                    b_m[i]  = 16'($urandom);
                    pa_m[i] = 1'($urandom);
                    pb_m[i] = 1'($urandom);
                end
            end
            if (pend == '0) set_req(int'($urandom_range(0, N - 1)), 16'($urandom), 16'($urandom));
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), 1'b0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
